adapter_serializer_1_to_4: RTL and testbench
============================================

Name: adapter_serializer_1_to_4

Overview:
Takes the packed N_INPUTS*DATA_WIDTH bus produced by the 4-to-1 adapter stage and emits it as N_INPUTS sequential DATA_WIDTH words over a valid/ready stream. It sits directly downstream of adapter_4_to_1 and narrows the wide bus for a word-wide consumer. Word r0 (the MSB slice) goes out first.

Parameters:
DATA_WIDTH, 16, width of one output word.
N_INPUTS, 4, number of words per packed input; must be >= 2.
CNT_WIDTH, 2, word index width; must satisfy 2**CNT_WIDTH >= N_INPUTS.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
r  input  N_INPUTS*DATA_WIDTH  packed input; r0 occupies the MSBs.
in_valid  input  1  r is valid.
in_ready  output  1  block accepts r this cycle.
out_data  output  DATA_WIDTH  current word.
out_valid  output  1  out_data is valid.
out_ready  input  1  consumer accepts out_data this cycle.
out_last  output  1  out_data is the final word (index N_INPUTS-1) of the packed input.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, count=0, shift register=0, out_valid=0, out_last=0, out_data=0. in_ready=1 from the first cycle after reset.
- Handshakes:
  - Input transfer occurs when in_valid&&in_ready.
  - Output transfer occurs when out_valid&&out_ready.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
- States:
  - IDLE: out_valid=0, in_ready=1. An input transfer loads r into the shift register, sets count=0 and moves to SEND.
  - SEND: out_valid=1 and out_data = top DATA_WIDTH bits of the shift register.
    - Output transfer with count<N_INPUTS-1: shift left by DATA_WIDTH, count+1.
    - Output transfer with count==N_INPUTS-1: go to IDLE, unless an input transfer happens in the same cycle; in that case load the new r, set count=0 and stay in SEND.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is a combinational path from out_ready to in_ready and is intended: it gives back-to-back packets with no bubble.
- out_last = (state==SEND) && (count==N_INPUTS-1).
- Latency and throughput:
  - First word is valid the cycle after the input transfer.
  - Steady-state throughput is one word per cycle, N_INPUTS cycles per packed input.
- in_valid while busy (in_ready=0): ignored, nothing loaded. The upstream holds r until accepted.
- No wrap-around beyond N_INPUTS-1: count returns to 0 only on a new load.
- reset mid-packet: the partial packet is discarded. All reset values apply on the next edge, and no out_last is emitted for the dropped packet.
- reset has priority over every simultaneous handshake.
- Unused count encodings, which occur only when N_INPUTS < 2**CNT_WIDTH, never occur.

Decomposition:
- Shared include header (guarded `ifndef, like the adapter files) holds:
  - default DATA_WIDTH and N_INPUTS;
  - state encodings ST_IDLE=1'b0, ST_SEND=1'b1.
- One natural sub-module: adapter_word_counter. It is a CNT_WIDTH-bit counter with sync reset, clear, enable and an is_last flag compared against N_INPUTS-1. It is reused by a future 1-to-4 deserializer.

Test Plan:
- Basic: r=64'h1111_2222_3333_4444, in_valid 1 cycle, out_ready=1.
  Required: out_data 1111, 2222, 3333, 4444 on four consecutive cycles; out_last only on 4444; in_ready low during words 1-3.
- Backpressure: same r, out_ready low for 3 cycles during word 2222.
  Required: out_data held at 2222 with out_valid=1 throughout; sequence otherwise unchanged.
- Back-to-back: in_valid held high with A=64'hAAAA_BBBB_CCCC_DDDD, then B=64'h0001_0002_0003_0004.
  Required: 8 consecutive valid words with no bubble; in_ready=1 exactly on the DDDD transfer cycle.
- Busy input: in_valid=1 with r=64'hFFFF_FFFF_FFFF_FFFF while sending 2222/3333.
  Required: not loaded until the 4444 transfer; then FFFF words follow.
- Reset mid-packet: assert reset after word 2222.
  Required: next cycle out_valid=0, out_last=0, in_ready=1; a new r=64'h5555_6666_7777_8888 emits 5555 first.
- Parameter variant: DATA_WIDTH=8, N_INPUTS=3, CNT_WIDTH=2, r=24'hA1B2C3.
  Required: A1, B2, C3 with out_last on C3.

Source files
------------

// File: rtl/adapter_serializer_1_to_4_pkg.sv
// Shared definitions for the 1-to-4 serializer adapter.
// Holds the default geometry of the packed input bus and the state encoding
// used by adapter_serializer_1_to_4.
package adapter_serializer_1_to_4_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_N_INPUTS   = 4;
  localparam int DEFAULT_CNT_WIDTH  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/adapter_word_counter.sv
// Word index counter for the adapter family.
// A CNT_WIDTH-bit counter with synchronous reset, clear and enable. is_last
// flags the final word index (N_INPUTS-1). Clear wins over enable so a new
// packet can restart the index in the same cycle the old one finishes.
//
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous, active-high reset
//   clear   - return count to 0
//   enable  - advance count by one
//   count   - current word index
//   is_last - count equals N_INPUTS-1
module adapter_word_counter #(
  parameter int CNT_WIDTH = 2,
  parameter int N_INPUTS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 is_last
);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values, independent of process ordering.
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

  assign is_last = (count == CNT_WIDTH'(N_INPUTS - 1));

endmodule

// File: rtl/adapter_serializer_1_to_4.sv
// 1-to-N serializer adapter.
// Accepts a packed N_INPUTS*DATA_WIDTH bus from the upstream 4-to-1 adapter
// and emits it as N_INPUTS DATA_WIDTH words on a valid/ready stream, MSB
// slice (r0) first. A new packet may be accepted in the same cycle the last
// word of the previous one is taken, so back-to-back packets have no bubble.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous, active-high reset
//   r         - packed input, r0 in the MSBs
//   in_valid  - r is valid
//   in_ready  - r is accepted this cycle (combinational from out_ready)
//   out_data  - current word
//   out_valid - out_data is valid
//   out_ready - consumer accepts out_data this cycle
//   out_last  - out_data is the final word of the packet
module adapter_serializer_1_to_4
  import adapter_serializer_1_to_4_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N_INPUTS   = DEFAULT_N_INPUTS,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] r,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last
);

  localparam int BUS_WIDTH = N_INPUTS * DATA_WIDTH;

  state_e                 state_q;
  state_e                 state_d;
  logic [BUS_WIDTH-1:0]   shift_q;
  logic [CNT_WIDTH-1:0]   count;
  logic                   is_last;
  logic                   load;
  logic                   out_fire;

  assign out_valid = (state_q == ST_SEND);
  assign out_last  = out_valid && is_last;
  assign out_fire  = out_valid && out_ready;
  // Taking the last word frees the block in the same cycle, which is what
  // lets the next packet load without an idle cycle in between.
  assign in_ready  = (state_q == ST_IDLE) || (out_fire && out_last);
  assign load      = in_valid && in_ready;
  assign out_data  = shift_q[BUS_WIDTH-1 -: DATA_WIDTH];

  always_comb begin
    // NOTE: next-state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load) state_d = ST_SEND;
      ST_SEND: if (out_fire && out_last && !load) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      // NOTE: the shift register is reset, not left free-running, because
      // its top slice is visible on out_data straight out of reset.
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        shift_q <= r;
      end else if (out_fire && !out_last) begin
        shift_q <= shift_q << DATA_WIDTH;
      end
    end
  end

  adapter_word_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .N_INPUTS  (N_INPUTS)
  ) u_word_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (load),
    .enable  (out_fire && !out_last),
    .count   (count),
    .is_last (is_last)
  );

  // The index never runs past the final word; encodings above N_INPUTS-1
  // are unreachable.
  assert property (@(posedge clk) disable iff (reset)
    count <= CNT_WIDTH'(N_INPUTS - 1));

endmodule

// File: tb/tb_adapter_serializer_1_to_4.sv
// Self-checking bench for adapter_serializer_1_to_4: default 16x4 instance
// plus an 8x3 parameter variant.
module tb_adapter_serializer_1_to_4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [63:0] r;
  logic        in_valid, in_ready;
  logic [15:0] out_data;
  logic        out_valid, out_ready, out_last;

  logic [23:0] r8;
  logic        in_valid8, in_ready8;
  logic [7:0]  out_data8;
  logic        out_valid8, out_ready8, out_last8;

  adapter_serializer_1_to_4 dut (
    .clk       (clk),
    .reset     (reset),
    .r         (r),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  adapter_serializer_1_to_4 #(
    .DATA_WIDTH (8),
    .N_INPUTS   (3),
    .CNT_WIDTH  (2)
  ) dut8 (
    .clk       (clk),
    .reset     (reset),
    .r         (r8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .out_data  (out_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_last  (out_last8)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [63:0]       r;
    logic [0:3][15:0]  w;
    int                stall_word;
    int                stall_cycles;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[4];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every output transfer must match the oldest
  // expected word.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_word: actual=%0h required=no output", out_data);
      end else begin
        e = sb.pop_front();
        check("sb_data", out_data, e.data);
        check("sb_last", out_last, e.last);
      end
    end
  end

  task automatic push_packet(input logic [0:3][15:0] w);
    for (int i = 0; i < 4; i++) sb.push_back('{w[i], (i == 3)});
  endtask

  // Hold in_valid until the block takes r; returns at posedge+1.
  task automatic drive_input(input logic [63:0] data);
    r        = data;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL accept_timeout: actual=in_ready 0 for 50 cycles required=1");
    in_valid = 1'b0;
  endtask

  // Let the scoreboard empty, optionally stalling one word for a few cycles.
  task automatic drain(input int stall_word, input int stall_cycles);
    int stalled = 0;
    int idx;
    for (int n = 0; n < 100; n++) begin
      if (sb.size() == 0) begin
        out_ready = 1'b1;
        return;
      end
      idx = 4 - sb.size();
      if (idx == stall_word && stalled < stall_cycles) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (!out_ready) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_hold", out_data, sb[0].data);
      end
      @(posedge clk);
      #1;
    end
    total++;
    bad++;
    $display("FAIL drain_timeout: actual=%0d words left required=0", sb.size());
    out_ready = 1'b1;
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk);
    check(name, out_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [0:3][15:0] bw;
    logic [0:2][7:0]  pw;

    vecs[0] = '{64'h1111_2222_3333_4444, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, -1, 0};
    vecs[1] = '{64'h1111_2222_3333_4444, {16'h1111, 16'h2222, 16'h3333, 16'h4444},  1, 3};
    vecs[2] = '{64'hDEAD_BEEF_0123_4567, {16'hDEAD, 16'hBEEF, 16'h0123, 16'h4567},  3, 2};
    vecs[3] = '{64'h8000_0001_7FFF_FFFE, {16'h8000, 16'h0001, 16'h7FFF, 16'hFFFE},  0, 1};

    reset      = 1'b1;
    r          = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    r8         = '0;
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, 16'h0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst8_out_valid", out_valid8, 1'b0);
    check("rst8_in_ready", in_ready8, 1'b1);
    @(posedge clk);
    #1;

    // Basic, checked cycle by cycle
    bw = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    push_packet(bw);
    r        = 64'h1111_2222_3333_4444;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("basic_valid", out_valid, 1'b1);
      check("basic_data", out_data, bw[i]);
      check("basic_last", out_last, (i == 3));
      check("basic_in_ready", in_ready, (i == 3));
      @(posedge clk);
      #1;
    end
    expect_idle("basic_idle");

    // Table of packets with assorted backpressure
    for (int v = 0; v < 4; v++) begin
      push_packet(vecs[v].w);
      drive_input(vecs[v].r);
      drain(vecs[v].stall_word, vecs[v].stall_cycles);
      expect_idle("vec_idle");
    end

    // Back-to-back: in_valid held across two packets
    push_packet({16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD});
    push_packet({16'h0001, 16'h0002, 16'h0003, 16'h0004});
    out_ready = 1'b1;
    r         = 64'hAAAA_BBBB_CCCC_DDDD;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    r = 64'h0001_0002_0003_0004;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_valid", out_valid, 1'b1);
      if (i < 4) check("b2b_in_ready", in_ready, (i == 3));
      @(posedge clk);
      #1;
      if (i == 3) in_valid = 1'b0;
    end
    expect_idle("b2b_idle");

    // Busy input: FFFF offered while 2222/3333 are out
    push_packet({16'h1111, 16'h2222, 16'h3333, 16'h4444});
    push_packet({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
    r        = 64'h1111_2222_3333_4444;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    r        = 64'hFFFF_FFFF_FFFF_FFFF;
    in_valid = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("busy_in_ready", in_ready, (i == 3));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain(-1, 0);
    expect_idle("busy_idle");

    // Reset mid-packet, asserted once 2222 has been taken
    push_packet({16'h1111, 16'h2222, 16'h3333, 16'h4444});
    r        = 64'h1111_2222_3333_4444;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_last", out_last, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    push_packet({16'h5555, 16'h6666, 16'h7777, 16'h8888});
    drive_input(64'h5555_6666_7777_8888);
    @(negedge clk);
    check("mid_rst_first", out_data, 16'h5555);
    @(posedge clk);
    #1;
    drain(-1, 0);
    expect_idle("mid_rst_idle");

    // Parameter variant 8x3
    pw         = {8'hA1, 8'hB2, 8'hC3};
    r8         = 24'hA1B2C3;
    in_valid8  = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("p8_valid", out_valid8, 1'b1);
      check("p8_data", out_data8, pw[i]);
      check("p8_last", out_last8, (i == 2));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("p8_idle", out_valid8, 1'b0);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
